// File: rtl/vecmat_mac_seq.sv
// Sequential dot-product engine: captures an input vector and a weight row,
// multiply-accumulates LANES elements per cycle, then rounds the fixed-point
// sum and saturates it to DATA_W with a one-cycle valid pulse.

// One lane: full-precision signed product, sign-extended to the accumulator width.
module vecmat_mac_lane #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 39
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  p_o
);
    logic signed [2*DATA_W-1:0] prod;

    assign prod = a_i * b_i;
    assign p_o  = ACC_W'(prod);
endmodule

module vecmat_mac_seq #(
    parameter int VEC_LEN   = 100,
    parameter int DATA_W    = 16,
    parameter int LANES     = 4,
    parameter int FRAC_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [VEC_LEN*DATA_W-1:0] data_x,
    input  logic [VEC_LEN*DATA_W-1:0] W_x,
    output logic                      busy,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         data_out_x
);
    localparam int ACC_W   = 2*DATA_W + $clog2(VEC_LEN);
    localparam int N_STEPS = (VEC_LEN + LANES - 1) / LANES;
    localparam int PAD_LEN = N_STEPS * LANES;
    localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    // Rounding constant and saturation bounds, held one bit wider than the
    // accumulator so adding the half-LSB can never wrap.
    localparam logic signed [ACC_W:0] HALF    = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS-1);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

    state_e                           state_q, state_d;
    logic [VEC_LEN-1:0][DATA_W-1:0]   x_q, w_q;
    logic signed [ACC_W-1:0]          acc_q, acc_d;
    logic [STEP_W-1:0]                step_q;
    logic                             vld_q;
    logic [DATA_W-1:0]                dout_q;

    // Operands regrouped per MAC step; indices past VEC_LEN are zero padding.
    logic [N_STEPS-1:0][LANES-1:0][DATA_W-1:0] x_grp, w_grp;
    logic [LANES-1:0][DATA_W-1:0]              lane_x, lane_w;
    logic [LANES-1:0][ACC_W-1:0]               lane_p;
    logic signed [ACC_W-1:0]                   step_sum;
    logic signed [ACC_W:0]                     rnd_sum, rnd_shr;
    logic [DATA_W-1:0]                         sat_res;
    logic                                      accept, last_step;

    assign x_grp  = (PAD_LEN*DATA_W)'(x_q);
    assign w_grp  = (PAD_LEN*DATA_W)'(w_q);
    assign lane_x = x_grp[step_q];
    assign lane_w = w_grp[step_q];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vecmat_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .a_i (lane_x[l]),
            .b_i (lane_w[l]),
            .p_o (lane_p[l])
        );
    end

    // Sum this step's lane products and fold them into the accumulator.
    always_comb begin
        step_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            step_sum = step_sum + $signed(lane_p[l]);
        end
        acc_d = acc_q + step_sum;
    end

    // Round half-up, arithmetic shift, then clamp to the signed DATA_W range.
    always_comb begin
        rnd_sum = {acc_q[ACC_W-1], acc_q} + HALF;
        rnd_shr = rnd_sum >>> FRAC_BITS;
        sat_res = rnd_shr[DATA_W-1:0];
        if (rnd_shr > SAT_MAX) begin
            sat_res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (rnd_shr < SAT_MIN) begin
            sat_res = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    assign accept    = (state_q == S_IDLE) && start;
    assign last_step = (step_q == STEP_W'(N_STEPS-1));

    // Next-state logic: IDLE -> MAC (N_STEPS edges) -> OUT (one edge) -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_MAC;
            S_MAC:   if (last_step) state_d = S_OUT;
            S_OUT:                  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: operand capture on accept, accumulate in MAC, publish in OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            w_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            vld_q <= (state_q == S_OUT);
            if (accept) begin
                x_q    <= data_x;
                w_q    <= W_x;
                acc_q  <= '0;
                step_q <= '0;
            end
            if (state_q == S_MAC) begin
                acc_q  <= acc_d;
                step_q <= step_q + 1'b1;
            end
            if (state_q == S_OUT) begin
                dout_q <= sat_res;
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign out_valid  = vld_q;
    assign data_out_x = dout_q;
endmodule
